mips_regfile_mp: RTL and testbench



---
 rtl/mips_regfile_pkg.sv | 15 +
 rtl/mips_regfile_if.sv | 27 ++
 rtl/mips_regfile_rdport.sv | 31 +++
 rtl/mips_regfile_mp.sv | 113 +++++++++++
 tb/tb_mips_regfile_mp.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared types and helpers for the multi-read-port MIPS register file.
package mips_regfile_pkg;

  // INIT walks the array writing zeros; RUN is normal read/write operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  // Number of entries addressed by an addr_w-bit register index.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/mips_regfile_if.sv
// Decode/writeback-facing bus of the register file. Read ports are packed
// flat: port i sits at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W].
interface mips_regfile_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic                         clear_req;
  logic [NUM_READ*ADDR_W-1:0]   read_reg;
  logic [NUM_READ*DATA_W-1:0]   read_data;
  logic [ADDR_W-1:0]            write_reg;
  logic [DATA_W-1:0]            write_data;
  logic                         RegWrite;
  logic                         ready;

  // Pipeline side driving addresses and write data.
  modport master (
    output clear_req, read_reg, write_reg, write_data, RegWrite,
    input  read_data, ready
  );

  // Register file side.
  modport slave (
    input  clear_req, read_reg, write_reg, write_data, RegWrite,
    output read_data, ready
  );
endinterface

// File: rtl/mips_regfile_rdport.sv
// One combinational read port: INIT gating, zero-register override and
// write-to-read bypass on top of the stored array value.
module mips_regfile_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              run,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_stored,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  // Priority: not-yet-cleared array, hardwired zero, forwarded write, array.
  always_comb begin
    rd_data = '0;
    if (!run)
      rd_data = '0;
    else if (ZERO_REG && rd_addr == '0)
      rd_data = '0;
    else if (BYPASS && byp_en && wr_addr == rd_addr)
      rd_data = wr_data;
    else
      rd_data = rd_stored;
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-read-port register file with a sequential clear engine.
// After reset or clear_req the array is zeroed one entry per clock; writes
// are dropped and reads return 0 until the sweep finishes and ready rises.
module mips_regfile_mp
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic           clock,
  input  logic           reset_n,
  mips_regfile_if.slave  bus
);

  localparam int                DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              run;
  logic              wr_ok;
  logic              byp_en;

  logic [NUM_READ-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_READ-1:0][DATA_W-1:0] rd_stored;
  logic [NUM_READ-1:0][DATA_W-1:0] rd_data;

  assign run      = (state == ST_RUN);
  assign bus.ready = run;

  // A write to a hardwired zero register is neither stored nor forwarded.
  assign wr_ok  = bus.RegWrite && !(ZERO_REG && bus.write_reg == '0);
  // clear_req kills the write, so it must not be forwarded either.
  assign byp_en = wr_ok && !bus.clear_req;

  // Clear engine next state: sweep clr_ptr to LAST, clear_req restarts it.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_INIT: begin
        if (bus.clear_req) begin
          clr_ptr_nxt = '0;
        end else if (clr_ptr == LAST) begin
          state_nxt   = ST_RUN;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.clear_req) begin
          state_nxt   = ST_INIT;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_INIT;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Clear engine state register; reset overrides everything.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Array update: zero sweep in INIT, writeback port in RUN. Reset leaves
  // contents alone; the following sweep takes care of them.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == ST_INIT)
        regs[clr_ptr] <= '0;
      else if (wr_ok && !bus.clear_req)
        regs[bus.write_reg] <= bus.write_data;
    end
  end

  assign rd_addr       = bus.read_reg;
  assign bus.read_data = rd_data;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    assign rd_stored[g] = regs[rd_addr[g]];

    mips_regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .run       (run),
      .byp_en    (byp_en),
      .rd_addr   (rd_addr[g]),
      .rd_stored (rd_stored[g]),
      .wr_addr   (bus.write_reg),
      .wr_data   (bus.write_data),
      .rd_data   (rd_data[g])
    );
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: DUT A (2 ports, bypass) and DUT B (3 ports,
// no bypass) share clock, reset, clear and write bus; a behavioural model
// predicts ready and every read port each cycle.
module tb_mips_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mips_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(2)) ifa ();
  mips_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(3)) ifb ();

  mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa.slave));
  mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(3), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: contents per DUT, running flag and edges left before ready.
  logic [31:0] m_regs [2][DEPTH];
  bit          m_run  = 1'b0;
  int          m_left = DEPTH;

  // Inputs currently applied.
  logic        clr, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra [2][3];

  function automatic logic [31:0] m_read(input int d, input logic [4:0] a);
    if (!m_run) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (d == 0 && we && !clr && wa == a) return wd;
    return m_regs[d][a];
  endfunction

  task automatic drv(input bit rn, input bit c, input bit w, input logic [4:0] a,
                     input logic [31:0] data, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2);
    @(negedge clock);
    reset_n = rn; clr = c; we = w; wa = a; wd = data;
    ra[0][0] = a0; ra[0][1] = a1; ra[0][2] = 5'd0;
    ra[1][0] = b0; ra[1][1] = b1; ra[1][2] = b2;
    ifa.clear_req = c; ifa.RegWrite = w; ifa.write_reg = a; ifa.write_data = data;
    ifb.clear_req = c; ifb.RegWrite = w; ifb.write_reg = a; ifb.write_data = data;
    ifa.read_reg = {a1, a0};
    ifb.read_reg = {b2, b1, b0};
    #1;
    chk("ready_a", 32'(ifa.ready), 32'(m_run));
    chk("ready_b", 32'(ifb.ready), 32'(m_run));
    for (int p = 0; p < 2; p++)
      chk($sformatf("rd_a%0d", p), ifa.read_data[p*32 +: 32], m_read(0, ra[0][p]));
    for (int p = 0; p < 3; p++)
      chk($sformatf("rd_b%0d", p), ifb.read_data[p*32 +: 32], m_read(1, ra[1][p]));
  endtask

  // Advance the model across one rising edge using the held inputs.
  task automatic stp();
    @(posedge clock);
    if (!reset_n) begin
      m_run = 1'b0; m_left = DEPTH;
    end else if (m_run) begin
      if (clr) begin
        m_run = 1'b0; m_left = DEPTH;
      end else if (we && wa != 5'd0) begin
        m_regs[0][wa] = wd; m_regs[1][wa] = wd;
      end
    end else if (clr) begin
      m_left = DEPTH;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b1;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < DEPTH; i++) m_regs[d][i] = 32'h0;
      end
    end
  endtask

  task automatic cyc(input bit rn, input bit c, input bit w, input logic [4:0] a,
                     input logic [31:0] data, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2);
    drv(rn, c, w, a, data, a0, a1, b0, b1, b2);
    stp();
  endtask

  initial begin
    logic [4:0]  ra0, ra1, rb0, rb1, rb2, rwa;
    ifa.clear_req = 0; ifa.RegWrite = 0; ifa.write_reg = 0; ifa.write_data = 0; ifa.read_reg = 0;
    ifb.clear_req = 0; ifb.RegWrite = 0; ifb.write_reg = 0; ifb.write_data = 0; ifb.read_reg = 0;
    clr = 0; we = 0; wa = 0; wd = 0;
    @(posedge clock);

    // 1: reset held 3 edges, then release with writes to reg 3 throughout
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 5'd3, $urandom, 3, 3, 3, 3, 3);
    for (int k = 0; k < DEPTH; k++) cyc(1, 0, 1, 5'd3, $urandom, 3, 3, 3, 3, 3);
    drv(1, 0, 0, 5'd0, 32'h0, 3, 3, 3, 3, 3);
    chk("t1_ready", 32'(ifa.ready), 32'd1);
    chk("t1_reg3", ifa.read_data[31:0], 32'h0);
    stp();

    // 2: write with same-cycle bypass, then stored read
    drv(1, 0, 1, 5'd3, 32'hFFFF_FFFF, 3, 1, 3, 3, 3);
    chk("t2_byp", ifa.read_data[31:0], 32'hFFFF_FFFF);
    chk("t2_rd1", ifa.read_data[63:32], 32'h0);
    stp();
    drv(1, 0, 0, 5'd3, 32'h0, 3, 1, 3, 3, 3);
    chk("t2_stored", ifa.read_data[31:0], 32'hFFFF_FFFF);
    stp();

    // 3: zero register ignores writes, including the bypass cycle
    drv(1, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk("t3_byp0", ifa.read_data[31:0], 32'h0);
    chk("t3_byp1", ifa.read_data[63:32], 32'h0);
    stp();
    drv(1, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 0);
    chk("t3_rd0", ifa.read_data[31:0], 32'h0);
    stp();

    // 4: soft clear collides with a write to reg 5
    cyc(1, 0, 1, 5'd5, 32'h0000_0055, 5, 5, 5, 5, 5);
    drv(1, 1, 1, 5'd5, 32'h1234_5678, 5, 5, 5, 5, 5);
    chk("t4_nobyp", ifa.read_data[31:0], 32'h0000_0055);
    stp();
    drv(1, 0, 1, 5'd5, 32'h1234_5678, 5, 5, 5, 5, 5);
    chk("t4_ready0", 32'(ifa.ready), 32'd0);
    chk("t4_init_rd", ifa.read_data[31:0], 32'h0);
    stp();
    for (int k = 1; k < DEPTH; k++) cyc(1, 0, 1, 5'd5, $urandom, 5, 5, 5, 5, 5);
    drv(1, 0, 0, 5'd0, 32'h0, 5, 5, 5, 5, 5);
    chk("t4_ready1", 32'(ifa.ready), 32'd1);
    chk("t4_reg5", ifa.read_data[31:0], 32'h0);
    stp();

    // 5: reset at clr_ptr=17 restarts the full sweep
    cyc(1, 1, 0, 5'd0, 32'h0, 1, 2, 1, 2, 3);
    for (int k = 0; k < 17; k++) cyc(1, 0, 0, 5'd0, 32'h0, 1, 2, 1, 2, 3);
    cyc(0, 0, 0, 5'd0, 32'h0, 1, 2, 1, 2, 3);
    for (int k = 0; k < DEPTH; k++) cyc(1, 0, 0, 5'd0, 32'h0, 1, 2, 1, 2, 3);
    drv(1, 0, 0, 5'd0, 32'h0, 1, 2, 1, 2, 3);
    chk("t5_ready", 32'(ifa.ready), 32'd1);
    stp();

    // 6: no-bypass DUT returns the old value in the write cycle
    drv(1, 0, 1, 5'd7, 32'h0000_ABCD, 7, 7, 7, 7, 7);
    for (int p = 0; p < 3; p++) chk($sformatf("t6_old%0d", p), ifb.read_data[p*32 +: 32], 32'h0);
    stp();
    drv(1, 0, 0, 5'd0, 32'h0, 7, 7, 7, 7, 7);
    for (int p = 0; p < 3; p++) chk($sformatf("t6_new%0d", p), ifb.read_data[p*32 +: 32], 32'h0000_ABCD);
    stp();

    // Random traffic with occasional reset and soft clear
    for (int k = 0; k < 3000; k++) begin
      rwa = ($urandom % 2) ? 5'($urandom % 8) : 5'($urandom);
      ra0 = ($urandom % 3 == 0) ? rwa : 5'($urandom % 12);
      ra1 = ($urandom % 3 == 0) ? rwa : 5'($urandom);
      rb0 = ($urandom % 3 == 0) ? rwa : 5'($urandom % 12);
      rb1 = 5'($urandom);
      rb2 = ra0;
      cyc(($urandom % 400) != 0, ($urandom % 200) == 0, 1'($urandom), rwa, $urandom,
          ra0, ra1, rb0, rb1, rb2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
